// File: rtl/ex_alu_muldiv.sv
// ex_alu_muldiv: registered EX-stage ALU with optional iterative MULT/DIV into HI/LO.
// Ports: i_clk, i_reset (sync, high); i_valid/o_ready request handshake; i_code funct;
//   i_data_1/i_data_2 operands; o_alu_result + o_valid one-cycle result pulse; o_busy.
// Build option: define IE_ALU_MULDIV_EN to add HI/LO, MFHI/MFLO and MULT/MULTU/DIV/DIVU.
module ex_alu_muldiv #(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_OP-1:0]   i_code,
  input  logic [NB_DATA-1:0] i_data_1,
  input  logic [NB_DATA-1:0] i_data_2,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic               o_valid,
  output logic               o_busy
);
  localparam int NB_SHAMT = $clog2(NB_DATA);

  localparam logic [NB_OP-1:0] OP_SLL  = NB_OP'(6'b000000);
  localparam logic [NB_OP-1:0] OP_SRL  = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OP_SRA  = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_ADD  = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB  = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND  = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR   = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR  = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR  = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SLT  = NB_OP'(6'b101010);
  localparam logic [NB_OP-1:0] OP_SLTU = NB_OP'(6'b101011);

  logic [NB_SHAMT-1:0] shamt;
  logic [NB_DATA-1:0]  alu_res;
  logic                accept;
  logic [NB_DATA-1:0]  result_q, result_d;
  logic                valid_q, valid_d;

`ifdef IE_ALU_MULDIV_EN
  localparam logic [NB_OP-1:0] OP_MFHI  = NB_OP'(6'b010000);
  localparam logic [NB_OP-1:0] OP_MFLO  = NB_OP'(6'b010010);
  localparam logic [NB_OP-1:0] OP_MULT  = NB_OP'(6'b011000);
  localparam logic [NB_OP-1:0] OP_MULTU = NB_OP'(6'b011001);
  localparam logic [NB_OP-1:0] OP_DIV   = NB_OP'(6'b011010);
  localparam logic [NB_OP-1:0] OP_DIVU  = NB_OP'(6'b011011);
  localparam int NB_CNT = $clog2(NB_DATA);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_e;

  state_e               state_q, state_d;
  logic [NB_DATA-1:0]   hi_q, hi_d;
  logic [NB_DATA-1:0]   lo_q, lo_d;
  logic [NB_DATA-1:0]   opb_q, opb_d;
  logic [2*NB_DATA-1:0] work_q, work_d;
  logic [NB_CNT-1:0]    cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;

  logic                 is_md, is_div_op, is_signed;
  logic                 sgn_1, sgn_2;
  logic [NB_DATA-1:0]   mag_1, mag_2;
  logic [NB_DATA:0]     mul_sum, rem_sh, rem_diff;
  logic                 div_ge;
  logic [NB_DATA-1:0]   rem_fix, quo_fix;
  logic [2*NB_DATA-1:0] prod_fix;
`endif

  assign shamt  = i_data_2[NB_SHAMT-1:0];
  assign accept = i_valid & o_ready;

  always_comb begin
    alu_res = '0;
    unique case (i_code)
      OP_ADD:  alu_res = i_data_1 + i_data_2;
      OP_SUB:  alu_res = i_data_1 - i_data_2;
      OP_AND:  alu_res = i_data_1 & i_data_2;
      OP_OR:   alu_res = i_data_1 | i_data_2;
      OP_XOR:  alu_res = i_data_1 ^ i_data_2;
      OP_NOR:  alu_res = ~(i_data_1 | i_data_2);
      OP_SRL:  alu_res = i_data_1 >> shamt;
      OP_SRA:  alu_res = NB_DATA'($signed(i_data_1) >>> shamt);
      OP_SLL:  alu_res = i_data_1 << shamt;
      OP_SLT:  alu_res = NB_DATA'($signed(i_data_1) < $signed(i_data_2));
      OP_SLTU: alu_res = NB_DATA'(i_data_1 < i_data_2);
`ifdef IE_ALU_MULDIV_EN
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
`endif
      default: alu_res = '0;
    endcase
  end

`ifdef IE_ALU_MULDIV_EN
  // Shared datapath: work_q holds {acc, multiplier} for mul
  // and {remainder, dividend/quotient} for div.
  always_comb begin
    is_md     = (i_code == OP_MULT) || (i_code == OP_MULTU) ||
                (i_code == OP_DIV)  || (i_code == OP_DIVU);
    is_div_op = (i_code == OP_DIV)  || (i_code == OP_DIVU);
    is_signed = (i_code == OP_MULT) || (i_code == OP_DIV);
    sgn_1     = is_signed & i_data_1[NB_DATA-1];
    sgn_2     = is_signed & i_data_2[NB_DATA-1];
    mag_1     = sgn_1 ? -i_data_1 : i_data_1;
    mag_2     = sgn_2 ? -i_data_2 : i_data_2;
    mul_sum   = {1'b0, work_q[2*NB_DATA-1:NB_DATA]} +
                (work_q[0] ? {1'b0, opb_q} : '0);
    rem_sh    = work_q[2*NB_DATA-1:NB_DATA-1];
    rem_diff  = rem_sh - {1'b0, opb_q};
    div_ge    = rem_sh >= {1'b0, opb_q};
    quo_fix   = neg_res_q ? -work_q[NB_DATA-1:0] : work_q[NB_DATA-1:0];
    rem_fix   = neg_rem_q ? -work_q[2*NB_DATA-1:NB_DATA]
                          : work_q[2*NB_DATA-1:NB_DATA];
    prod_fix  = neg_res_q ? -work_q : work_q;
  end
`endif

  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
`ifdef IE_ALU_MULDIV_EN
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && is_md) begin
          is_div_d  = is_div_op;
          cnt_d     = '0;
          neg_res_d = sgn_1 ^ sgn_2;
          neg_rem_d = sgn_1;
          state_d   = ST_RUN;
          if (!is_div_op) begin
            opb_d     = mag_1;
            work_d    = {{NB_DATA{1'b0}}, mag_2};
            neg_rem_d = 1'b0;
          end else if (i_data_2 == '0) begin
            // Nothing to iterate: preload the divide-by-zero answer.
            work_d    = {i_data_1, {NB_DATA{1'b1}}};
            neg_res_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = ST_FIX;
          end else begin
            opb_d  = mag_2;
            work_d = {{NB_DATA{1'b0}}, mag_1};
          end
        end else if (accept) begin
          result_d = alu_res;
          valid_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (is_div_q) begin
          work_d = {(div_ge ? rem_diff[NB_DATA-1:0] : rem_sh[NB_DATA-1:0]),
                    work_q[NB_DATA-2:0], div_ge};
        end else begin
          work_d = {mul_sum, work_q[NB_DATA-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == NB_CNT'(NB_DATA-1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`else
    if (accept) begin
      result_d = alu_res;
      valid_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      result_q  <= '0;
      valid_q   <= 1'b0;
`ifdef IE_ALU_MULDIV_EN
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      result_q  <= result_d;
      valid_q   <= valid_d;
`ifdef IE_ALU_MULDIV_EN
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign o_alu_result = result_q;
  assign o_valid      = valid_q;
`ifdef IE_ALU_MULDIV_EN
  assign o_ready = (state_q == ST_IDLE);
  assign o_busy  = ~o_ready;
`else
  assign o_ready = 1'b1;
  assign o_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_ex_alu_muldiv.sv
// tb_ex_alu_muldiv: randomized self-checking bench for ex_alu_muldiv (NB_DATA=32).
// Expected values come from an arithmetic reference model; follows IE_ALU_MULDIV_EN.
module tb_ex_alu_muldiv;
`ifdef IE_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic        rdy;
  logic [5:0]  code;
  logic [31:0] d1;
  logic [31:0] d2;
  logic [31:0] res;
  logic        ovld;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;
  logic [31:0] res_m;

  logic [5:0] alu_codes [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
    6'h27, 6'h02, 6'h03, 6'h00, 6'h2A, 6'h2B, 6'h10, 6'h12};

  ex_alu_muldiv #(.NB_DATA(32), .NB_OP(6)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_valid(vld),
    .o_ready(rdy),
    .i_code(code),
    .i_data_1(d1),
    .i_data_2(d2),
    .o_alu_result(res),
    .o_valid(ovld),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Reference model: expected result and accept->o_valid latency.
  task automatic model(input logic [5:0] c, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r,
                       output int lat);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    logic [4:0]  sh;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sh  = b[4:0];
    r   = 32'h0;
    lat = 1;
    case (c)
      6'h20: r = a + b;
      6'h22: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h02: r = a >> sh;
      6'h03: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      6'h00: r = a << sh;
      6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: r = (a < b) ? 32'd1 : 32'd0;
      6'h10: r = MD ? hi_m : 32'h0;
      6'h12: r = MD ? lo_m : 32'h0;
      6'h18, 6'h19, 6'h1A, 6'h1B: begin
        if (MD) begin
          r   = res_m;
          lat = 34;
          if (c == 6'h18) begin
            p = sa * sb;
            hi_m = p[63:32]; lo_m = p[31:0];
          end else if (c == 6'h19) begin
            p = {32'h0, a} * {32'h0, b};
            hi_m = p[63:32]; lo_m = p[31:0];
          end else if (b == 32'h0) begin
            lat = 2; hi_m = a; lo_m = 32'hFFFF_FFFF;
          end else if (c == 6'h1A && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            hi_m = 32'h0; lo_m = 32'h8000_0000;
          end else if (c == 6'h1A) begin
            sq = sa / sb; sr = sa % sb;
            hi_m = sr[31:0]; lo_m = sq[31:0];
          end else begin
            hi_m = a % b; lo_m = a / b;
          end
        end
      end
      default: r = 32'h0;
    endcase
    res_m = r;
  endtask

  // Issue one request and wait (bounded) for its o_valid pulse.
  task automatic drive_op(input logic [5:0] c, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] r,
                          output int lat, output bit bok);
    vld = 1'b1; code = c; d1 = a; d2 = b;
    step();
    vld = 1'b0;
    lat = 1;
    bok = 1'b1;
    while (ovld !== 1'b1 && lat < 100) begin
      if (rdy !== 1'b0 || busy !== 1'b1) bok = 1'b0;
      step();
      lat++;
    end
    if (ovld !== 1'b1) lat = -1;
    r = res;
  endtask

  task automatic test_reset();
    logic [31:0] r, er;
    int l, el;
    bit bok;
    rst = 1'b1; vld = 1'b0;
    step(); step();
    rst = 1'b0;
    hi_m = 0; lo_m = 0; res_m = 0;
    n_total++; if (res !== 32'h0) $display("FAIL reset_result got %h want %h", res, 32'h0); else n_pass++;
    n_total++; if (ovld !== 1'b0) $display("FAIL reset_valid got %b want 0", ovld); else n_pass++;
    n_total++; if (rdy !== 1'b1) $display("FAIL reset_ready got %b want 1", rdy); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    model(6'h10, 32'h0, 32'h0, er, el);
    drive_op(6'h10, $urandom, $urandom, r, l, bok);
    n_total++; if (r !== er) $display("FAIL reset_hi got %h want %h", r, er); else n_pass++;
    model(6'h12, 32'h0, 32'h0, er, el);
    drive_op(6'h12, $urandom, $urandom, r, l, bok);
    n_total++; if (r !== er) $display("FAIL reset_lo got %h want %h", r, er); else n_pass++;
  endtask

  task automatic test_spec_alu();
    logic [31:0] r, er;
    int l, el;
    bit bok;
    model(6'h20, 32'h7FFF_FFFF, 32'h1, er, el);
    drive_op(6'h20, 32'h7FFF_FFFF, 32'h1, r, l, bok);
    n_total++; if (r !== 32'h8000_0000) $display("FAIL add_wrap got %h want %h", r, 32'h8000_0000); else n_pass++;
    n_total++; if (l !== 1) $display("FAIL add_latency got %0d want 1", l); else n_pass++;
    step();
    n_total++; if (ovld !== 1'b0) $display("FAIL add_pulse got %b want 0", ovld); else n_pass++;
    model(6'h03, 32'h8000_0000, 32'h4, er, el);
    drive_op(6'h03, 32'h8000_0000, 32'h4, r, l, bok);
    n_total++; if (r !== 32'hF800_0000) $display("FAIL sra_sign got %h want %h", r, 32'hF800_0000); else n_pass++;
    model(6'h2A, 32'hFFFF_FFFF, 32'h1, er, el);
    drive_op(6'h2A, 32'hFFFF_FFFF, 32'h1, r, l, bok);
    n_total++; if (r !== 32'h1) $display("FAIL slt_neg got %h want %h", r, 32'h1); else n_pass++;
    model(6'h2B, 32'hFFFF_FFFF, 32'h1, er, el);
    drive_op(6'h2B, 32'hFFFF_FFFF, 32'h1, r, l, bok);
    n_total++; if (r !== 32'h0) $display("FAIL sltu_big got %h want %h", r, 32'h0); else n_pass++;
  endtask

  task automatic test_random_alu();
    logic [31:0] a, b, r, er;
    logic [5:0] c;
    int l, el;
    bit bok;
    for (int i = 0; i < 40; i++) begin
      a = rnd_data(); b = rnd_data();
      if (i % 8 == 7) c = 6'($urandom_range(0, 63));
      else c = alu_codes[$urandom_range(0, 12)];
      model(c, a, b, er, el);
      drive_op(c, a, b, r, l, bok);
      n_total++; if (r !== er) $display("FAIL rnd_alu code %h a %h b %h got %h want %h", c, a, b, r, er); else n_pass++;
      n_total++; if (l !== el) $display("FAIL rnd_lat code %h got %0d want %0d", c, l, el); else n_pass++;
      step();
      n_total++; if (ovld !== 1'b0) $display("FAIL rnd_pulse code %h got %b want 0", c, ovld); else n_pass++;
    end
  endtask

  task automatic run_md(input logic [5:0] c, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] r, er;
    int l, el;
    bit bok;
    model(c, a, b, er, el);
    drive_op(c, a, b, r, l, bok);
    n_total++; if (l !== el) $display("FAIL %s_latency got %0d want %0d", tag, l, el); else n_pass++;
    n_total++; if (r !== er) $display("FAIL %s_result got %h want %h", tag, r, er); else n_pass++;
    n_total++; if (bok !== 1'b1) $display("FAIL %s_ready_low got %b want 1", tag, bok); else n_pass++;
    model(6'h10, 32'h0, 32'h0, er, el);
    drive_op(6'h10, 32'h0, 32'h0, r, l, bok);
    n_total++; if (r !== er) $display("FAIL %s_hi got %h want %h", tag, r, er); else n_pass++;
    model(6'h12, 32'h0, 32'h0, er, el);
    drive_op(6'h12, 32'h0, 32'h0, r, l, bok);
    n_total++; if (r !== er) $display("FAIL %s_lo got %h want %h", tag, r, er); else n_pass++;
  endtask

  task automatic test_muldiv_vectors();
    run_md(6'h18, 32'hFFFF_FFFE, 32'h3, "mult_neg");
    run_md(6'h1A, 32'hFFFF_FFF9, 32'h2, "div_neg");
    run_md(6'h1B, 32'h7, 32'h0, "divu_zero");
    run_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, "div_min");
  endtask

  task automatic test_muldiv_random();
    for (int i = 0; i < 10; i++) begin
      run_md(6'(6'h18 + $urandom_range(0, 3)), rnd_data(), rnd_data(), "md_rnd");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, er;
    logic [5:0] c;
    int el;
    vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = rnd_data(); b = rnd_data();
      c = alu_codes[$urandom_range(0, 12)];
      model(c, a, b, er, el);
      code = c; d1 = a; d2 = b;
      step();
      n_total++; if (ovld !== 1'b1) $display("FAIL b2b_valid idx %0d got %b want 1", i, ovld); else n_pass++;
      n_total++; if (res !== er) $display("FAIL b2b_result idx %0d got %h want %h", i, res, er); else n_pass++;
    end
    vld = 1'b0;
    step();
    n_total++; if (ovld !== 1'b0) $display("FAIL b2b_idle got %b want 0", ovld); else n_pass++;
  endtask

  task automatic test_hold();
    logic [31:0] a, b, x, y, er1, er2, r1, r2;
    int el1, el2, p1, p2, np, n;
    a = rnd_data(); b = rnd_data(); x = $urandom; y = $urandom;
    model(6'h18, a, b, er1, el1);
    model(6'h20, x, y, er2, el2);
    vld = 1'b1; code = 6'h18; d1 = a; d2 = b;
    step();
    code = 6'h20; d1 = x; d2 = y;
    n = 1; np = 0; p1 = -1; p2 = -1; r1 = 32'h0; r2 = 32'h0;
    repeat (60) begin
      if (ovld === 1'b1) begin
        np++;
        if (np == 1) begin p1 = n; r1 = res; end
        else if (np == 2) begin p2 = n; r2 = res; vld = 1'b0; end
      end
      step();
      n++;
    end
    vld = 1'b0;
    n_total++; if (np !== 2) $display("FAIL hold_pulses got %0d want 2", np); else n_pass++;
    n_total++; if (p1 !== el1) $display("FAIL hold_mult_cycle got %0d want %0d", p1, el1); else n_pass++;
    n_total++; if (p2 !== el1 + 1) $display("FAIL hold_add_cycle got %0d want %0d", p2, el1 + 1); else n_pass++;
    n_total++; if (r1 !== er1) $display("FAIL hold_mult_result got %h want %h", r1, er1); else n_pass++;
    n_total++; if (r2 !== er2) $display("FAIL hold_add_result got %h want %h", r2, er2); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    logic [31:0] r, er, dummy;
    int l, el, np, exp_np;
    bit bok;
    model(6'h18, 32'h1234_5677, 32'h0000_1003, dummy, el);
    vld = 1'b1; code = 6'h18; d1 = 32'h1234_5677; d2 = 32'h0000_1003;
    step();
    vld = 1'b0;
    np = int'(ovld);
    repeat (10) begin step(); np += int'(ovld); end
    rst = 1'b1;
    step();
    np += int'(ovld);
    rst = 1'b0;
    hi_m = 0; lo_m = 0; res_m = 0;
    n_total++; if (rdy !== 1'b1) $display("FAIL midrst_ready got %b want 1", rdy); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
    n_total++; if (res !== 32'h0) $display("FAIL midrst_result got %h want %h", res, 32'h0); else n_pass++;
    repeat (40) begin step(); np += int'(ovld); end
    exp_np = (el <= 11) ? 1 : 0;
    n_total++; if (np !== exp_np) $display("FAIL midrst_pulses got %0d want %0d", np, exp_np); else n_pass++;
    model(6'h10, 32'h0, 32'h0, er, l);
    drive_op(6'h10, 32'h0, 32'h0, r, l, bok);
    n_total++; if (r !== er) $display("FAIL midrst_hi got %h want %h", r, er); else n_pass++;
    model(6'h12, 32'h0, 32'h0, er, l);
    drive_op(6'h12, 32'h0, 32'h0, r, l, bok);
    n_total++; if (r !== er) $display("FAIL midrst_lo got %h want %h", r, er); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; code = 6'h0; d1 = 32'h0; d2 = 32'h0;
    hi_m = 0; lo_m = 0; res_m = 0;
    test_reset();
    test_spec_alu();
    test_random_alu();
    test_muldiv_vectors();
    test_muldiv_random();
    test_back_to_back();
    test_hold();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
